// File: rtl/code_lock_pkg.sv
// State encodings and default parameter values shared by the code lock,
// its bus interface and its tick prescaler.
package code_lock_pkg;

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_OPEN    = 3'd1,
        ST_FAIL    = 3'd2,
        ST_LOCKOUT = 3'd3,
        ST_PROGRAM = 3'd4
    } state_t;

    localparam int DEF_DIGIT_W    = 4;
    localparam int DEF_CODE_LEN   = 4;
    localparam int DEF_MAX_TRIES  = 3;
    localparam int DEF_LOCK_TICKS = 10;
    localparam int DEF_TICK_DIV   = 50_000_000;

    // Digits 2,0,1,4 with the first digit in the most significant slot.
    localparam logic [DEF_CODE_LEN*DEF_DIGIT_W-1:0] DEF_CODE = 16'h2014;

endpackage

// File: rtl/code_lock_if.sv
// Keypad-side bus of the code lock: digit strobe in, status and progress out.
interface code_lock_if
    import code_lock_pkg::*;
#(
    parameter int DIGIT_W   = DEF_DIGIT_W,
    parameter int CODE_LEN  = DEF_CODE_LEN,
    parameter int MAX_TRIES = DEF_MAX_TRIES
);

    localparam int PROG_W  = $clog2(CODE_LEN + 1);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);

    logic [DIGIT_W-1:0] digit;
    logic               enter;
    logic               prog;
    logic               unlocked;
    logic               fail;
    logic               alarm;
    logic [PROG_W-1:0]  progress;
    logic [TRIES_W-1:0] tries_left;
    logic [2:0]         state_o;
    logic               tick;

    modport master (
        output digit, enter, prog,
        input  unlocked, fail, alarm, progress, tries_left, state_o, tick
    );

    modport slave (
        input  digit, enter, prog,
        output unlocked, fail, alarm, progress, tries_left, state_o, tick
    );

endinterface

// File: rtl/code_lock_tick_gen.sv
// Free-running prescaler: registered one-cycle pulse every TICK_DIV clocks,
// the first one on the TICK_DIV-th rising edge after reset release.
module tick_gen
    import code_lock_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (int'(cnt) == TICK_DIV - 1) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/code_lock.sv
// Digit-entry combination lock with retry limit, timed lockout and an
// in-field reprogramming mode entered from the OPEN state.
module code_lock
    import code_lock_pkg::*;
#(
    parameter int DIGIT_W    = DEF_DIGIT_W,
    parameter int CODE_LEN   = DEF_CODE_LEN,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = DEF_CODE,
    parameter int MAX_TRIES  = DEF_MAX_TRIES,
    parameter int LOCK_TICKS = DEF_LOCK_TICKS,
    parameter int TICK_DIV   = DEF_TICK_DIV
) (
    input logic        clk,
    input logic        rst,
    code_lock_if.slave bus
);

    localparam int CODE_W  = CODE_LEN * DIGIT_W;
    localparam int PROG_W  = $clog2(CODE_LEN + 1);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int LOCK_W  = (LOCK_TICKS > 1) ? $clog2(LOCK_TICKS + 1) : 1;

    typedef logic [CODE_W-1:0]  code_t;
    typedef logic [DIGIT_W-1:0] digit_t;

    // Slot 0 is the first digit of a sequence and lives in the MS position.
    function automatic digit_t get_slot(code_t v, int idx);
        return v[(CODE_LEN-1-idx)*DIGIT_W +: DIGIT_W];
    endfunction

    function automatic code_t put_slot(code_t v, int idx, digit_t d);
        code_t r;
        r = v;
        r[(CODE_LEN-1-idx)*DIGIT_W +: DIGIT_W] = d;
        return r;
    endfunction

    state_t             state;
    logic [PROG_W-1:0]  progress;
    logic               mismatch;
    logic [TRIES_W-1:0] tries_left;
    code_t              code;
    code_t              staging;
    logic [LOCK_W-1:0]  lock_cnt;
    logic               unlocked;
    logic               fail;
    logic               alarm;
    logic               tick;
    logic               slot_miss;
    logic               last_digit;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign slot_miss  = (bus.digit != get_slot(code, int'(progress)));
    assign last_digit = (int'(progress) == CODE_LEN - 1);

    // NOTE: the code and staging registers are reset like ordinary flops: the
    // lock must come up with a known code, so they cannot be left as RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_ENTRY;
            progress   <= '0;
            mismatch   <= 1'b0;
            tries_left <= TRIES_W'(MAX_TRIES);
            code       <= DEFAULT_CODE;
            staging    <= '0;
            lock_cnt   <= '0;
            unlocked   <= 1'b0;
            fail       <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            case (state)
                ST_ENTRY: begin
                    // Every digit is consumed; a wrong code is only revealed at the end.
                    if (bus.enter) begin
                        if (last_digit) begin
                            progress <= '0;
                            mismatch <= 1'b0;
                            if (!(mismatch || slot_miss)) begin
                                state      <= ST_OPEN;
                                unlocked   <= 1'b1;
                                tries_left <= TRIES_W'(MAX_TRIES);
                            end else if (tries_left > TRIES_W'(1)) begin
                                state      <= ST_FAIL;
                                fail       <= 1'b1;
                                tries_left <= tries_left - 1'b1;
                            end else begin
                                state      <= ST_LOCKOUT;
                                alarm      <= 1'b1;
                                tries_left <= '0;
                                lock_cnt   <= '0;
                            end
                        end else begin
                            progress <= progress + 1'b1;
                            mismatch <= mismatch | slot_miss;
                        end
                    end
                end

                ST_OPEN: begin
                    if (bus.enter) begin
                        unlocked <= 1'b0;
                        progress <= '0;
                        state    <= bus.prog ? ST_PROGRAM : ST_ENTRY;
                    end
                end

                ST_FAIL: begin
                    if (tick) begin
                        state <= ST_ENTRY;
                        fail  <= 1'b0;
                    end
                end

                ST_LOCKOUT: begin
                    if (tick) begin
                        if (int'(lock_cnt) == LOCK_TICKS - 1) begin
                            state      <= ST_ENTRY;
                            alarm      <= 1'b0;
                            tries_left <= TRIES_W'(MAX_TRIES);
                            lock_cnt   <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end
                end

                ST_PROGRAM: begin
                    // The live code only changes once the final digit arrives.
                    if (bus.enter) begin
                        if (last_digit) begin
                            code     <= put_slot(staging, CODE_LEN - 1, bus.digit);
                            staging  <= put_slot(staging, CODE_LEN - 1, bus.digit);
                            progress <= '0;
                            state    <= ST_ENTRY;
                        end else begin
                            staging  <= put_slot(staging, int'(progress), bus.digit);
                            progress <= progress + 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= ST_ENTRY;
                    progress <= '0;
                    mismatch <= 1'b0;
                    lock_cnt <= '0;
                    unlocked <= 1'b0;
                    fail     <= 1'b0;
                    alarm    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.unlocked   = unlocked;
    assign bus.fail       = fail;
    assign bus.alarm      = alarm;
    assign bus.progress   = progress;
    assign bus.tries_left = tries_left;
    assign bus.state_o    = state;
    assign bus.tick       = tick;

endmodule

// File: tb/tb_code_lock.sv
// Self-checking bench for code_lock: a directed vector table, hand-written
// multi-cycle sequences and random traffic against a behavioural model.
module tb_code_lock;
    import code_lock_pkg::*;

    localparam int DIGIT_W    = 4;
    localparam int CODE_LEN   = 4;
    localparam int MAX_TRIES  = 3;
    localparam int LOCK_TICKS = 5;
    localparam int TICK_DIV   = 4;
    localparam int NVEC       = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    code_lock_if #(.DIGIT_W(DIGIT_W), .CODE_LEN(CODE_LEN), .MAX_TRIES(MAX_TRIES)) bus ();

    code_lock #(
        .DIGIT_W      (DIGIT_W),
        .CODE_LEN     (CODE_LEN),
        .DEFAULT_CODE (16'h2014),
        .MAX_TRIES    (MAX_TRIES),
        .LOCK_TICKS   (LOCK_TICKS),
        .TICK_DIV     (TICK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: mode numbers follow the documented state encodings.
    localparam int M_ENTRY = 0, M_OPEN = 1, M_FAIL = 2, M_LOCKOUT = 3, M_PROGRAM = 4;

    int m_state;
    int m_tries;
    int m_code [CODE_LEN];
    int m_stage [CODE_LEN];
    int m_nstaged;
    int m_entered [$];
    int m_lock_ticks;
    int m_cycles;
    bit m_tick;

    task automatic model_reset();
        m_state      = M_ENTRY;
        m_tries      = MAX_TRIES;
        m_code       = '{2, 0, 1, 4};
        m_nstaged    = 0;
        m_entered.delete();
        m_lock_ticks = 0;
        m_cycles     = 0;
        m_tick       = 1'b0;
    endtask

    task automatic model_step(input bit en, input int dig, input bit pr);
        bit tick_in;
        bit ok;
        tick_in = m_tick;
        case (m_state)
            M_ENTRY: if (en) begin
                m_entered.push_back(dig);
                if (m_entered.size() == CODE_LEN) begin
                    ok = 1'b1;
                    for (int i = 0; i < CODE_LEN; i++)
                        if (m_entered[i] != m_code[i]) ok = 1'b0;
                    m_entered.delete();
                    if (ok) begin
                        m_state = M_OPEN;
                        m_tries = MAX_TRIES;
                    end else if (m_tries > 1) begin
                        m_state = M_FAIL;
                        m_tries = m_tries - 1;
                    end else begin
                        m_state      = M_LOCKOUT;
                        m_tries      = 0;
                        m_lock_ticks = 0;
                    end
                end
            end
            M_OPEN: if (en) begin
                m_nstaged = 0;
                m_state   = pr ? M_PROGRAM : M_ENTRY;
            end
            M_FAIL: if (tick_in) m_state = M_ENTRY;
            M_LOCKOUT: if (tick_in) begin
                m_lock_ticks++;
                if (m_lock_ticks == LOCK_TICKS) begin
                    m_state = M_ENTRY;
                    m_tries = MAX_TRIES;
                end
            end
            M_PROGRAM: if (en) begin
                m_stage[m_nstaged] = dig;
                m_nstaged++;
                if (m_nstaged == CODE_LEN) begin
                    m_code    = m_stage;
                    m_nstaged = 0;
                    m_state   = M_ENTRY;
                end
            end
            default: m_state = M_ENTRY;
        endcase
        m_cycles++;
        m_tick = (m_cycles % TICK_DIV) == 0;
    endtask

    function automatic logic [11:0] exp_bundle();
        int prg;
        prg = (m_state == M_ENTRY) ? m_entered.size() :
              (m_state == M_PROGRAM) ? m_nstaged : 0;
        return {3'(m_state), m_state == M_OPEN, m_state == M_FAIL, m_state == M_LOCKOUT,
                3'(prg), 2'(m_tries), m_tick};
    endfunction

    function automatic logic [11:0] act_bundle();
        return {bus.state_o, bus.unlocked, bus.fail, bus.alarm, bus.progress, bus.tries_left, bus.tick};
    endfunction

    // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
    task automatic cycle(input logic en, input logic [3:0] dig, input logic pr);
        bus.enter = en;
        bus.digit = dig;
        bus.prog  = pr;
        @(posedge clk);
        model_step(en, int'(dig), pr);
        @(negedge clk);
        bus.enter = 1'b0;
        check($sformatf("model_cycle%0d", m_cycles), act_bundle(), exp_bundle());
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < CODE_LEN; i++) cycle(1'b1, c[15-4*i -: 4], 1'b0);
    endtask

    // Reset asserted away from any clock edge, so the check proves it is asynchronous.
    task automatic do_reset(input string name);
        rst = 1'b0;
        #1;
        model_reset();
        check(name, act_bundle(), {3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd3, 1'b0});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_entry(input string name);
        for (int k = 0; k < 4 * TICK_DIV * LOCK_TICKS && bus.state_o != 3'd0; k++)
            cycle(1'b0, 4'd0, 1'b0);
        check(name, bus.state_o, 3'd0);
    endtask

    typedef struct {
        logic       en;
        logic [3:0] dig;
        logic       pr;
        logic [2:0] st;
        logic       unl;
        logic       fl;
        logic [2:0] prg;
        logic [1:0] tr;
    } vec_t;

    vec_t vecs [NVEC];

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n_ticks;

        vecs[0]  = '{1'b1, 4'd2, 1'b0, 3'd0, 1'b0, 1'b0, 3'd1, 2'd3};
        vecs[1]  = '{1'b1, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd2, 2'd3};
        vecs[2]  = '{1'b1, 4'd1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 2'd3};
        vecs[3]  = '{1'b1, 4'd4, 1'b0, 3'd1, 1'b1, 1'b0, 3'd0, 2'd3};
        vecs[4]  = '{1'b0, 4'd0, 1'b0, 3'd1, 1'b1, 1'b0, 3'd0, 2'd3};
        vecs[5]  = '{1'b1, 4'd9, 1'b1, 3'd4, 1'b0, 1'b0, 3'd0, 2'd3};
        vecs[6]  = '{1'b1, 4'd7, 1'b0, 3'd4, 1'b0, 1'b0, 3'd1, 2'd3};
        vecs[7]  = '{1'b1, 4'd7, 1'b0, 3'd4, 1'b0, 1'b0, 3'd2, 2'd3};
        vecs[8]  = '{1'b1, 4'd3, 1'b0, 3'd4, 1'b0, 1'b0, 3'd3, 2'd3};
        vecs[9]  = '{1'b1, 4'd1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 2'd3};
        vecs[10] = '{1'b1, 4'd2, 1'b0, 3'd0, 1'b0, 1'b0, 3'd1, 2'd3};
        vecs[11] = '{1'b1, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd2, 2'd3};
        vecs[12] = '{1'b1, 4'd1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 2'd3};
        vecs[13] = '{1'b1, 4'd4, 1'b0, 3'd2, 1'b0, 1'b1, 3'd0, 2'd2};

        bus.enter = 1'b0;
        bus.digit = '0;
        bus.prog  = 1'b0;
        @(negedge clk);
        do_reset("reset_values");

        // First tick lands on the TICK_DIV-th cycle; an enter alongside it still counts.
        for (k = 0; k < TICK_DIV + 2 && !bus.tick; k++) cycle(1'b0, 4'd0, 1'b0);
        check("first_tick_cycle", k, TICK_DIV);
        cycle(1'b1, 4'd2, 1'b0);
        check("enter_with_tick_progress", bus.progress, 3'd1);
        cycle(1'b1, 4'd0, 1'b0);
        cycle(1'b1, 4'd1, 1'b0);
        cycle(1'b1, 4'd4, 1'b0);
        check("default_code_opens", {bus.unlocked, bus.tries_left}, {1'b1, 2'd3});

        // Open, reprogram to 7,7,3,1, then the old code must be rejected.
        do_reset("reset_before_table");
        for (int i = 0; i < NVEC; i++) begin
            cycle(vecs[i].en, vecs[i].dig, vecs[i].pr);
            check($sformatf("vec%0d", i),
                  {bus.state_o, bus.unlocked, bus.fail, bus.progress, bus.tries_left},
                  {vecs[i].st, vecs[i].unl, vecs[i].fl, vecs[i].prg, vecs[i].tr});
        end
        wait_entry("reprog_fail_to_entry");
        enter_code(16'h7731);
        check("new_code_opens", {bus.unlocked, bus.tries_left}, {1'b1, 2'd3});

        // Wrong code: no reaction until the last digit, then FAIL ignoring enters.
        do_reset("reset_before_wrong");
        cycle(1'b1, 4'd9, 1'b0);
        cycle(1'b1, 4'd0, 1'b0);
        cycle(1'b1, 4'd1, 1'b0);
        check("no_early_reject", {bus.state_o, bus.fail, bus.progress}, {3'd0, 1'b0, 3'd3});
        cycle(1'b1, 4'd4, 1'b0);
        check("wrong_code_fail", {bus.fail, bus.tries_left}, {1'b1, 2'd2});
        for (k = 0; k < 2 * TICK_DIV && bus.state_o == 3'd2; k++) cycle(1'b1, 4'd2, 1'b0);
        check("fail_exit_to_entry", bus.state_o, 3'd0);
        check("fail_enters_ignored", bus.progress, 3'd0);

        // Three failures lock out for exactly LOCK_TICKS ticks.
        do_reset("reset_before_lockout");
        for (int t = 0; t < MAX_TRIES; t++) begin
            enter_code(16'h9999);
            if (t < MAX_TRIES - 1) wait_entry($sformatf("retry%0d_entry", t));
        end
        check("lockout_alarm", {bus.alarm, bus.tries_left}, {1'b1, 2'd0});
        n_ticks = 0;
        for (k = 0; k < 100 && bus.alarm; k++) begin
            if (bus.tick) n_ticks++;
            cycle(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        check("lockout_ticks", n_ticks, LOCK_TICKS);
        check("lockout_exit", {bus.state_o, bus.tries_left, bus.progress}, {3'd0, 2'd3, 3'd0});
        enter_code(16'h2014);
        check("open_after_lockout", bus.unlocked, 1'b1);

        // Reset in the middle of programming discards the partial code.
        do_reset("reset_before_midprog");
        enter_code(16'h2014);
        cycle(1'b1, 4'd0, 1'b1);
        cycle(1'b1, 4'd7, 1'b0);
        cycle(1'b1, 4'd7, 1'b0);
        check("midprog_progress", {bus.state_o, bus.progress}, {3'd4, 3'd2});
        do_reset("midprog_reset_values");
        enter_code(16'h2014);
        check("default_code_survives", bus.unlocked, 1'b1);

        // Random traffic, biased towards correct digits so OPEN and PROGRAM are reached.
        do_reset("reset_before_random");
        for (int n = 0; n < 3000; n++) begin
            logic       en;
            logic [3:0] dig;
            logic       pr;
            if ($urandom_range(0, 799) == 0) do_reset($sformatf("random_reset%0d", n));
            en  = ($urandom_range(0, 2) == 0);
            pr  = ($urandom_range(0, 3) == 0);
            dig = 4'($urandom_range(0, 15));
            if (m_state == M_ENTRY && $urandom_range(0, 1) == 1)
                dig = 4'(m_code[m_entered.size()]);
            cycle(en, dig, pr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
